powlib_ipsaxi_rd: RTL and testbench
===================================

POWLIB_IPSAXI_RD -- requirements
Module: powlib_ipsaxi_rd

Interface
REQ-001 Parameters SHALL be: ID "IPSAXI_RD", debug/report tag string; IDW 1, AXI ID width; B_BPD 4, bytes per beat; B_AW 32, address width; RD_D 8, response FIFO depth (power of 2, >=2).
REQ-002 Derived: B_DW = 8*B_BPD; outstanding/beat counters SHALL be 8-bit plus FIFO-pointer width log2(RD_D)+1.
REQ-003 clk  in  1  sole clock; all state on rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 arid/araddr/arlen/arsize/arburst  in  IDW/B_AW/8/3/2  AXI read address.
REQ-006 arvalid in 1, arready out 1  AR handshake.
REQ-007 rid/rdata/rresp/rlast  out  IDW/B_DW/2/1  AXI read data.
REQ-008 rvalid out 1, rready in 1  R handshake.
REQ-009 reqaddr out B_AW, reqvld out 1, reqrdy in 1  internal read-request channel.
REQ-010 rspdata in B_DW, rspvld in 1, rsprdy out 1  internal read-response channel, in-order.

Function
REQ-011 FSM states SHALL be IDLE, ISSUE, DRAIN; one AXI burst in flight at a time.
REQ-012 IDLE: arready=1; on arvalid&arready, capture arid, araddr, arlen; go to ISSUE next cycle.
REQ-013 ISSUE: reqvld SHALL assert the cycle after AR handshake; arlen+1 requests issued, each accepted on reqvld&reqrdy.
REQ-014 reqaddr SHALL start at captured araddr and add B_BPD per accepted request, modulo 2^B_AW; no 4KB boundary check.
REQ-015 Credit rule: reqvld SHALL deassert when outstanding requests + FIFO occupancy == RD_D; FIFO never overflows.
REQ-016 rsprdy SHALL be constant 1 outside reset; rspvld SHALL push rspdata into FIFO same cycle.
REQ-017 After last request accepted, ISSUE -> DRAIN; DRAIN -> IDLE on final R handshake (rlast&rvalid&rready); arready re-asserts the following cycle.
REQ-018 rvalid = FIFO non-empty; rdata = FIFO head; rid = captured arid; rresp = 2'b00 (OKAY).
REQ-019 rlast SHALL assert on the beat where R beat counter == captured arlen; counter clears on rlast handshake.
REQ-020 rvalid stall (rready=0): rdata/rid/rlast SHALL hold stable; FIFO simultaneous push+pop SHALL keep occupancy unchanged.
REQ-021 arlen=0: single request, single beat with rlast=1.
REQ-022 Minimum latency AR handshake -> first rvalid: 2 cycles plus internal response latency.

Reset
REQ-023 During rst=0 and the first edge after release: arready=0, reqvld=0, rsprdy=0, rvalid=0, rlast=0, rresp=0, rid=0, reqaddr=0, rdata=0.
REQ-024 First rising edge after rst deasserts SHALL enter IDLE with arready=1.
REQ-025 Reset mid-burst SHALL flush FIFO, clear all counters, discard in-flight responses; no partial burst resumes.

Configuration
REQ-026 Macro POWLIB_IPSAXI_RD_BURSTCHK_EN: when defined, a burst with arburst!=2'b01 (INCR) or arsize!=log2(B_BPD) SHALL issue no internal requests and return arlen+1 beats, rdata=0, rresp=2'b10 (SLVERR), rlast on final beat.
REQ-027 When undefined, arburst and arsize SHALL be ignored; every burst treated as INCR full-width.

Verification
REQ-028 Reset: hold rst=0 5 cycles, release -> all outputs zero, arready=1 on 1st cycle after release.
REQ-029 araddr=0x100, arlen=3, arid=1, responder returns 0xA0..0xA3 with 1-cycle latency, rready=1 -> reqaddr 0x100,0x104,0x108,0x10C; 4 beats rdata A0..A3, rid=1, rlast on 4th only, rresp=0.
REQ-030 arlen=15, rready=0 for 20 cycles -> reqvld drops after 8 accepted requests, FIFO holds 8, no data loss; release rready -> 16 beats in order.
REQ-031 araddr=0xFFFFFFFC, arlen=1 -> reqaddr 0xFFFFFFFC then 0x00000000.
REQ-032 With POWLIB_IPSAXI_RD_BURSTCHK_EN, arburst=2'b00, arlen=2 -> no reqvld, 3 beats rresp=2'b10, rdata=0; without macro -> normal OKAY burst.
REQ-033 Assert rst=0 after 2 of 8 beats returned -> rvalid=0 immediately; after release, new arlen=0 burst completes with correct single beat.

Source files
------------

// File: rtl/powlib_ipsaxi_rd.sv
// AXI read slave bridging one burst at a time onto an in-order internal request/response channel.
// Optional burst legality check (SLVERR return) enabled by defining POWLIB_IPSAXI_RD_BURSTCHK_EN.
module powlib_ipsaxi_rd #(
    parameter     ID    = "IPSAXI_RD",
    parameter int IDW   = 1,
    parameter int B_BPD = 4,
    parameter int B_AW  = 32,
    parameter int RD_D  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [IDW-1:0]       arid,
    input  logic [B_AW-1:0]      araddr,
    input  logic [7:0]           arlen,
    input  logic [2:0]           arsize,
    input  logic [1:0]           arburst,
    input  logic                 arvalid,
    output logic                 arready,
    output logic [IDW-1:0]       rid,
    output logic [8*B_BPD-1:0]   rdata,
    output logic [1:0]           rresp,
    output logic                 rlast,
    output logic                 rvalid,
    input  logic                 rready,
    output logic [B_AW-1:0]      reqaddr,
    output logic                 reqvld,
    input  logic                 reqrdy,
    input  logic [8*B_BPD-1:0]   rspdata,
    input  logic                 rspvld,
    output logic                 rsprdy
);

    localparam int B_DW = 8 * B_BPD;
    localparam int FA   = $clog2(RD_D);
    localparam int PW   = FA + 1;
    localparam int TW   = PW + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t            state_r;
    logic              arready_r;
    logic              rsprdy_r;
    logic              reqvld_r;
    logic [B_AW-1:0]   reqaddr_r;
    logic [IDW-1:0]    id_r;
    logic [7:0]        len_r;
    logic [7:0]        iss_r;
    logic [7:0]        beat_r;
    logic [PW-1:0]     out_r;
    logic [PW-1:0]     wptr_r;
    logic [PW-1:0]     rptr_r;
    logic              err_r;
    logic [B_DW-1:0]   mem_r [RD_D];

    logic [PW-1:0]     cnt_s;
    logic              push_s;
    logic              acc_s;
    logic              rvalid_s;
    logic              pop_s;
    logic              fpop_s;
    logic              last_s;
    logic              fin_s;
    logic              load_s;
    logic              bad_s;
    logic [TW-1:0]     total_s;
    logic              unused_s;

`ifdef POWLIB_IPSAXI_RD_BURSTCHK_EN
    assign bad_s = (arburst != 2'b01) || (arsize != 3'($clog2(B_BPD)));
`else
    assign bad_s = 1'b0;
`endif
    assign unused_s = ^{arsize, arburst, ID};

    assign cnt_s    = wptr_r - rptr_r;
    assign push_s   = rspvld && rsprdy_r && (out_r != {PW{1'b0}});
    assign acc_s    = reqvld_r && reqrdy;
    assign rvalid_s = err_r ? (state_r == DRAIN) : (cnt_s != {PW{1'b0}});
    assign pop_s    = rvalid_s && rready;
    assign fpop_s   = pop_s && !err_r;
    assign last_s   = rvalid_s && (beat_r == len_r);
    assign fin_s    = pop_s && last_s;
    assign load_s   = (state_r == IDLE) && arready_r && arvalid;
    // Credit seen next cycle: requests in flight plus buffered beats must never exceed the FIFO depth.
    assign total_s  = TW'(out_r) + TW'(cnt_s) + TW'(acc_s) - TW'(fpop_s);

    assign arready = arready_r;
    assign rsprdy  = rsprdy_r;
    assign reqvld  = reqvld_r;
    assign reqaddr = reqaddr_r;
    assign rid     = id_r;
    assign rvalid  = rvalid_s;
    assign rlast   = last_s;
    assign rresp   = (rvalid_s && err_r) ? 2'b10 : 2'b00;
    assign rdata   = (rvalid_s && !err_r) ? mem_r[rptr_r[FA-1:0]] : {B_DW{1'b0}};

    // Response FIFO storage; contents are only observed through the reset-cleared pointers.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wptr_r[FA-1:0]] <= rspdata;
        end
    end

    // Burst control FSM, credit tracking and FIFO pointers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= IDLE;
            arready_r <= 1'b0;
            rsprdy_r  <= 1'b0;
            reqvld_r  <= 1'b0;
            reqaddr_r <= {B_AW{1'b0}};
            id_r      <= {IDW{1'b0}};
            len_r     <= 8'd0;
            iss_r     <= 8'd0;
            beat_r    <= 8'd0;
            out_r     <= {PW{1'b0}};
            wptr_r    <= {PW{1'b0}};
            rptr_r    <= {PW{1'b0}};
            err_r     <= 1'b0;
        end else begin
            rsprdy_r <= 1'b1;
            out_r    <= out_r + PW'(acc_s) - PW'(push_s);
            if (push_s) begin
                wptr_r <= wptr_r + PW'(1);
            end
            if (fpop_s) begin
                rptr_r <= rptr_r + PW'(1);
            end
            if (pop_s) begin
                beat_r <= fin_s ? 8'd0 : beat_r + 8'd1;
            end
            if (acc_s) begin
                reqaddr_r <= reqaddr_r + B_AW'(B_BPD);
                iss_r     <= iss_r + 8'd1;
            end
            case (state_r)
                IDLE: begin
                    if (load_s) begin
                        arready_r <= 1'b0;
                        id_r      <= arid;
                        len_r     <= arlen;
                        reqaddr_r <= araddr;
                        iss_r     <= 8'd0;
                        beat_r    <= 8'd0;
                        if (bad_s) begin
                            err_r    <= 1'b1;
                            reqvld_r <= 1'b0;
                            state_r  <= DRAIN;
                        end else begin
                            err_r    <= 1'b0;
                            reqvld_r <= 1'b1;
                            state_r  <= ISSUE;
                        end
                    end else begin
                        arready_r <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (acc_s && (iss_r == len_r)) begin
                        reqvld_r <= 1'b0;
                        state_r  <= DRAIN;
                    end else begin
                        reqvld_r <= (total_s < TW'(RD_D));
                    end
                end
                DRAIN: begin
                    if (fin_s) begin
                        arready_r <= 1'b1;
                        err_r     <= 1'b0;
                        state_r   <= IDLE;
                    end else begin
                        reqvld_r <= 1'b0;
                    end
                end
                default: begin
                    state_r  <= IDLE;
                    reqvld_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_powlib_ipsaxi_rd.sv
// Randomized bench for powlib_ipsaxi_rd: a queue-based responder plus a per-burst expectation model.
module tb_powlib_ipsaxi_rd;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [0:0]  arid = 1'b0;
    logic [31:0] araddr = 32'h0;
    logic [7:0]  arlen = 8'h0;
    logic [2:0]  arsize = 3'd2;
    logic [1:0]  arburst = 2'b01;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [0:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready = 1'b0;
    logic [31:0] reqaddr;
    logic        reqvld;
    logic        reqrdy = 1'b0;
    logic [31:0] rspdata = 32'h0;
    logic        rspvld = 1'b0;
    logic        rsprdy;

    int ncmp = 0;
    int nerr = 0;

    typedef struct {
        logic [31:0] d;
        int          due;
    } rsp_t;
    rsp_t        pend[$];
    logic [31:0] req_log[$];
    logic [31:0] data_base = 32'h0;
    int          cyc = 0;
    int          rsp_mode = 0;

    logic [31:0] exp_addr;
    int          exp_len;
    logic        exp_id;
    bit          exp_err;

    powlib_ipsaxi_rd dut (
        .clk(clk), .rst(rst),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .reqaddr(reqaddr), .reqvld(reqvld), .reqrdy(reqrdy),
        .rspdata(rspdata), .rspvld(rspvld), .rsprdy(rsprdy)
    );

    always #5 clk = ~clk;

    // In-order responder: data = base + request index, returned one or more cycles after acceptance.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (!rst) begin
            pend.delete();
            rspvld = 1'b0;
            reqrdy = 1'b0;
        end else begin
            if (pend.size() > 0 && pend[0].due <= cyc) begin
                rspvld  = 1'b1;
                rspdata = pend[0].d;
                void'(pend.pop_front());
            end else begin
                rspvld  = 1'b0;
                rspdata = $urandom;
            end
            reqrdy = (rsp_mode != 0) ? 1'b1 : ($urandom_range(3) != 0);
            if (reqvld && reqrdy) begin
                pend.push_back('{data_base + 32'(req_log.size()),
                                 cyc + 1 + ((rsp_mode != 0) ? 0 : int'($urandom_range(2)))});
                req_log.push_back(reqaddr);
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send_ar(input logic [31:0] addr, input int len, input logic id,
                           input logic [1:0] burst, input logic [31:0] base);
        int t = 0;
        exp_addr  = addr;
        exp_len   = len;
        exp_id    = id;
`ifdef POWLIB_IPSAXI_RD_BURSTCHK_EN
        exp_err   = (burst != 2'b01);
`else
        exp_err   = 1'b0;
`endif
        data_base = base;
        req_log.delete();
        araddr  = addr;
        arlen   = 8'(len);
        arid    = id;
        arburst = burst;
        arsize  = 3'd2;
        arvalid = 1'b1;
        while (!arready && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("ar_ready", {63'h0, arready}, 64'h1);
        @(negedge clk);
        arvalid = 1'b0;
        chk("ar_busy", {63'h0, arready}, 64'h0);
        chk("reqvld_lat", {63'h0, reqvld}, {63'h0, !exp_err});
    endtask

    task automatic collect(input int stop_n, input int rr_pct);
        int  k = 0;
        int  t = 0;
        bit  done = 1'b0;
        while (!done && t < 3000) begin
            rready = ($urandom_range(99) < rr_pct);
            if (rvalid && rready) begin
                chk("beat", {28'h0, rid, rresp, rlast, rdata},
                    {28'h0, exp_id, (exp_err ? 2'b10 : 2'b00), 1'(k == exp_len),
                     (exp_err ? 32'h0 : data_base + 32'(k))});
                k++;
                if (k == exp_len + 1 || k == stop_n) done = 1'b1;
            end
            @(negedge clk);
            t++;
        end
        rready = 1'b0;
        chk("beat_count", 64'(k), 64'((stop_n < exp_len + 1) ? stop_n : exp_len + 1));
        if (k == exp_len + 1) begin
            chk("ar_back", {62'h0, arready, rvalid}, 64'h2);
        end
    endtask

    task automatic check_reqs();
        chk("req_n", 64'(req_log.size()), 64'(exp_err ? 0 : exp_len + 1));
        foreach (req_log[i]) begin
            chk("reqaddr", {32'h0, req_log[i]}, {32'h0, exp_addr + 32'(i * 4)});
        end
    endtask

    initial begin
        repeat (5) @(negedge clk);
        chk("rst_out", {26'h0, arready, reqvld, rsprdy, rvalid, rlast, rresp, rid},
            64'h0);
        chk("rst_data", {reqaddr, rdata}, 64'h0);
        rst = 1'b1;
        chk("rel_ar0", {63'h0, arready}, 64'h0);
        @(negedge clk);
        chk("rel_ar1", {62'h0, arready, rsprdy}, 64'h3);

        // Directed INCR burst with fixed one-cycle responder.
        rsp_mode = 1;
        send_ar(32'h100, 3, 1'b1, 2'b01, 32'hA0);
        collect(99, 100);
        check_reqs();

        // Backpressure: credit limit stops issue at FIFO depth.
        send_ar(32'h2000, 15, 1'b0, 2'b01, 32'h5000_0000);
        repeat (20) @(negedge clk);
        chk("credit_reqs", 64'(req_log.size()), 64'd8);
        chk("credit_vld", {63'h0, reqvld}, 64'h0);
        chk("stall_head", {30'h0, rvalid, rlast, rdata}, {30'h0, 1'b1, 1'b0, 32'h5000_0000});
        collect(99, 100);
        check_reqs();

        // Address wrap at top of the address space.
        rsp_mode = 0;
        send_ar(32'hFFFF_FFFC, 1, 1'b1, 2'b01, 32'h1234_0000);
        collect(99, 70);
        check_reqs();

        // Non-INCR burst: SLVERR with the check built in, plain burst otherwise.
        send_ar(32'h200, 2, 1'b0, 2'b00, 32'h7700);
        collect(99, 80);
        check_reqs();

        for (int b = 0; b < 6; b++) begin
            send_ar($urandom & 32'hFFFF_FFFC, int'($urandom_range(15)), 1'($urandom),
                    2'b01, $urandom);
            collect(99, int'($urandom_range(100, 30)));
            check_reqs();
        end

        // Reset in the middle of a burst, then a fresh single-beat burst.
        rsp_mode = 1;
        send_ar(32'h300, 7, 1'b1, 2'b01, 32'hBEEF_0000);
        collect(2, 100);
        rst = 1'b0;
        #1;
        chk("mid_rst", {61'h0, rvalid, arready, reqvld}, 64'h0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_ar", {62'h0, arready, rvalid}, 64'h2);
        send_ar(32'h400, 0, 1'b0, 2'b01, 32'hCAFE_0000);
        collect(99, 100);
        check_reqs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
